// File: rtl/voice_phase_scheduler_if.sv
// Bus between the sample-rate timer / config master and the voice phase scheduler.
interface voice_phase_scheduler_if #(
  parameter int VOICES = 8,
  parameter int IDXW   = $clog2(VOICES)
);
  logic              sample_tick;
  logic [VOICES-1:0] voice_en;
  logic              cfg_we;
  logic              cfg_sel;
  logic [IDXW-1:0]   cfg_addr;
  logic [15:0]       cfg_data;
  logic              ovr_clr;
  logic              busy;
  logic              phase_valid;
  logic [IDXW-1:0]   voice_idx;
  logic [15:0]       phase_out;
  logic              wrap;
  logic              sweep_done;
  logic              overrun;

  modport master (
    output sample_tick, voice_en, cfg_we, cfg_sel, cfg_addr, cfg_data, ovr_clr,
    input  busy, phase_valid, voice_idx, phase_out, wrap, sweep_done, overrun
  );

  modport slave (
    input  sample_tick, voice_en, cfg_we, cfg_sel, cfg_addr, cfg_data, ovr_clr,
    output busy, phase_valid, voice_idx, phase_out, wrap, sweep_done, overrun
  );
endinterface

// File: rtl/voice_phase_scheduler.sv
// One shared 16-bit ripple adder swept over all voice phase accumulators per sample tick.

// 8-bit ripple-carry full-adder stage.
module vps_add8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  output logic [7:0] s_o,
  output logic       c_o
);
  logic [8:0] cy;

  assign cy[0] = c_i;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ cy[i];
    assign cy[i+1]  = (a_i[i] & b_i[i]) | (cy[i] & (a_i[i] ^ b_i[i]));
  end
  assign c_o = cy[8];
endmodule

module voice_phase_scheduler #(
  parameter int VOICES = 8,
  parameter int IDXW   = $clog2(VOICES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  voice_phase_scheduler_if.slave bus
);
  localparam logic [0:0]      IDLE = 1'b0;
  localparam logic [0:0]      RUN  = 1'b1;
  localparam logic [IDXW-1:0] LAST = IDXW'(VOICES - 1);
  localparam int              NSTG = 2;

  logic [0:0]      state_q, state_d;
  logic [IDXW-1:0] k_q, k_d;
  logic            ovr_q, ovr_d;
  logic [15:0]     phase_q [VOICES];
  logic [15:0]     inc_q   [VOICES];

  logic            vld_q;
  logic [IDXW-1:0] idx_q;
  logic [15:0]     pout_q;
  logic            wrap_q;
  logic            done_q;

  // shared adder: two chained 8-bit stages, carry-in tied low
  logic [NSTG-1:0][7:0] add_a, add_b, add_s;
  logic [NSTG:0]        add_c;
  logic [15:0]          sum;
  logic                 carry;

  assign add_a    = phase_q[k_q];
  assign add_b    = inc_q[k_q];
  assign add_c[0] = 1'b0;

  for (genvar g = 0; g < NSTG; g++) begin : g_stg
    vps_add8 u_add8 (
      .a_i (add_a[g]),
      .b_i (add_b[g]),
      .c_i (add_c[g]),
      .s_o (add_s[g]),
      .c_o (add_c[g+1])
    );
  end

  assign sum   = add_s;
  assign carry = add_c[NSTG];

  logic run, en, last;
  assign run  = (state_q == RUN);
  assign en   = bus.voice_en[k_q];
  assign last = (k_q == LAST);

  // sweep FSM, slot counter and sticky overrun next-state
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    // a tick that collides with a sweep beats a same-cycle clear
    ovr_d   = (bus.ovr_clr ? 1'b0 : ovr_q) | (bus.sample_tick & run);
    if (!run) begin
      if (bus.sample_tick) begin
        state_d = RUN;
        k_d     = '0;
      end
    end else if (last) begin
      state_d = IDLE;
      k_d     = '0;
    end else begin
      k_d = k_q + 1'b1;
    end
  end

  // state, register files, write-back and registered result outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      ovr_q   <= 1'b0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      pout_q  <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int v = 0; v < VOICES; v++) begin
        phase_q[v] <= '0;
        inc_q[v]   <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ovr_q   <= ovr_d;
      vld_q   <= run;
      done_q  <= run & last;
      wrap_q  <= run & en & carry;
      if (run) begin
        idx_q  <= k_q;
        // disabled voices report their held phase and consume the slot
        pout_q <= en ? sum : phase_q[k_q];
        if (en) phase_q[k_q] <= sum;
      end
      // config write lands after write-back so a same-slot preset wins
      if (bus.cfg_we) begin
        if (bus.cfg_sel) phase_q[bus.cfg_addr] <= bus.cfg_data;
        else             inc_q[bus.cfg_addr]   <= bus.cfg_data;
      end
    end
  end

  assign bus.busy        = run;
  assign bus.phase_valid = vld_q;
  assign bus.voice_idx   = idx_q;
  assign bus.phase_out   = pout_q;
  assign bus.wrap        = wrap_q;
  assign bus.sweep_done  = done_q;
  assign bus.overrun     = ovr_q;
endmodule

// File: tb/tb_voice_phase_scheduler.sv
// Scoreboard bench for voice_phase_scheduler: a cycle model pushes expected results, the monitor pops them.
module tb_voice_phase_scheduler;
  localparam int V  = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  voice_phase_scheduler_if #(.VOICES(V), .IDXW(IW)) bus ();
  voice_phase_scheduler #(.VOICES(V), .IDXW(IW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          idx;
    logic [15:0] ph;
    logic        wr;
    logic        dn;
  } exp_t;

  exp_t        sbq [$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_ph  [V];
  logic [15:0] m_inc [V];
  logic        m_busy, m_ovr;
  int          m_k;
  logic [15:0] obs_ph [V];
  logic        obs_wr [V];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // reference behaviour evaluated at each rising edge from the driven inputs
  task automatic model_update();
    logic [16:0] s;
    logic        en;
    exp_t        e;
    if (!reset_n) begin
      m_busy = 1'b0; m_k = 0; m_ovr = 1'b0;
      for (int v = 0; v < V; v++) begin m_ph[v] = '0; m_inc[v] = '0; end
      sbq.delete();
      return;
    end
    if (m_busy) begin
      s     = {1'b0, m_ph[m_k]} + {1'b0, m_inc[m_k]};
      en    = bus.voice_en[m_k];
      e.idx = m_k;
      e.ph  = en ? s[15:0] : m_ph[m_k];
      e.wr  = en & s[16];
      e.dn  = (m_k == V - 1);
      sbq.push_back(e);
      if (en) m_ph[m_k] = s[15:0];
    end
    if (bus.cfg_we) begin
      if (bus.cfg_sel) m_ph[bus.cfg_addr]  = bus.cfg_data;
      else             m_inc[bus.cfg_addr] = bus.cfg_data;
    end
    m_ovr = (bus.ovr_clr ? 1'b0 : m_ovr) | (bus.sample_tick & m_busy);
    if (!m_busy) begin
      if (bus.sample_tick) begin m_busy = 1'b1; m_k = 0; end
    end else if (m_k == V - 1) begin
      m_busy = 1'b0;
    end else begin
      m_k++;
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("valid", bus.phase_valid, 1);
      chk("idx",   bus.voice_idx, e.idx);
      chk("phase", bus.phase_out, e.ph);
      chk("wrap",  bus.wrap, e.wr);
      chk("done",  bus.sweep_done, e.dn);
      obs_ph[e.idx] = bus.phase_out;
      obs_wr[e.idx] = bus.wrap;
    end else begin
      chk("valid_idle", bus.phase_valid, 0);
      chk("done_idle",  bus.sweep_done, 0);
    end
    chk("busy",    bus.busy, m_busy);
    chk("overrun", bus.overrun, m_ovr);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
    monitor();
  endtask

  task automatic cfg(input logic sel, input int addr, input logic [15:0] data);
    bus.cfg_we = 1'b1; bus.cfg_sel = sel; bus.cfg_addr = IW'(addr); bus.cfg_data = data;
    cyc();
    bus.cfg_we = 1'b0;
  endtask

  task automatic tick();
    bus.sample_tick = 1'b1;
    cyc();
    bus.sample_tick = 1'b0;
  endtask

  task automatic sweep();
    tick();
    repeat (V) cyc();
  endtask

  task automatic clr_obs();
    for (int v = 0; v < V; v++) begin obs_ph[v] = 16'hFFFF; obs_wr[v] = 1'b1; end
  endtask

  initial begin
    bus.sample_tick = 1'b0; bus.voice_en = '1; bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0;
    bus.cfg_addr = '0; bus.cfg_data = '0; bus.ovr_clr = 1'b0;
    clr_obs();

    // reset state
    repeat (2) cyc();
    reset_n = 1'b1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.phase_valid, 0);
    chk("rst_phase", bus.phase_out, 0);
    chk("rst_wrap", bus.wrap, 0);
    chk("rst_idx", bus.voice_idx, 0);
    chk("rst_done", bus.sweep_done, 0);
    chk("rst_ovr", bus.overrun, 0);
    cyc();

    // single increment, two sweeps
    cfg(1'b0, 0, 16'h0100);
    clr_obs();
    sweep();
    chk("t1_v0", obs_ph[0], 16'h0100);
    chk("t1_v1", obs_ph[1], 16'h0000);
    chk("t1_v7", obs_ph[7], 16'h0000);
    sweep();
    chk("t1_v0_2nd", obs_ph[0], 16'h0200);

    // wrap on voice 3
    cfg(1'b1, 3, 16'hFFF0);
    cfg(1'b0, 3, 16'h0020);
    clr_obs();
    sweep();
    chk("t2_ph3", obs_ph[3], 16'h0010);
    chk("t2_wr3", obs_wr[3], 1);
    chk("t2_wr0", obs_wr[0], 0);
    chk("t2_wr4", obs_wr[4], 0);

    // disabled voice 5 over three sweeps
    bus.voice_en = 8'hDF;
    cfg(1'b0, 5, 16'h1234);
    repeat (3) sweep();
    chk("t3_ph5", obs_ph[5], 16'h0000);
    chk("t3_wr5", obs_wr[5], 0);
    bus.voice_en = '1;

    // overrun and earliest back-to-back tick
    tick();
    repeat (3) cyc();
    tick();
    chk("t4_ovr_set", bus.overrun, 1);
    bus.ovr_clr = 1'b1;
    cyc();
    bus.ovr_clr = 1'b0;
    chk("t4_ovr_clr", bus.overrun, 0);
    repeat (3) cyc();
    tick();
    chk("t4_busy_next", bus.busy, 1);
    repeat (V) cyc();

    // increment rewritten during its own slot
    cfg(1'b1, 2, 16'h0000);
    cfg(1'b0, 2, 16'h0001);
    tick();
    repeat (2) cyc();
    cfg(1'b0, 2, 16'h0500);
    repeat (V - 3) cyc();
    chk("t5_old_inc", obs_ph[2], 16'h0001);
    sweep();
    chk("t5_new_inc", obs_ph[2], 16'h0501);

    // phase preset during its own slot wins over write-back
    tick();
    repeat (2) cyc();
    cfg(1'b1, 2, 16'hABCD);
    repeat (V - 3) cyc();
    chk("t5_preset_out", obs_ph[2], 16'h0A01);
    clr_obs();
    sweep();
    chk("t5_preset_next", obs_ph[2], 16'hB0CD);

    // reset mid-sweep
    tick();
    repeat (3) cyc();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk("t6_busy", bus.busy, 0);
    chk("t6_valid", bus.phase_valid, 0);
    cyc();
    chk("t6_valid2", bus.phase_valid, 0);
    clr_obs();
    sweep();
    for (int v = 0; v < V; v++) begin
      chk("t6_ph", obs_ph[v], 16'h0000);
      chk("t6_wr", obs_wr[v], 0);
    end
    chk("sbq_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
